// File: rtl/aes_inv_sub_bytes.sv
// Multi-cycle AES InvSubBytes engine: BYTES_PER_CYCLE inverse S-box lookups per BUSY cycle,
// with valid/ready handshakes on both the input and output sides.
module aes_inv_sub_bytes #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned N  = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW = 8 * BYTES_PER_CYCLE;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] grp;
  logic [127:0]  work;
  logic [6:0]    base;
  logic [GW-1:0] sub_in;
  logic [GW-1:0] sub_out;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    sq = gf_mul(x, x);
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      r  = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] s;
    s = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(s);
  endfunction

  always_comb begin
    base   = 7'(32'(grp) * GW);
    sub_in = work[base +: GW];
  end

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_lut
    assign sub_out[8*i +: 8] = inv_sbox(sub_in[8*i +: 8]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grp       <= '0;
      work      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_state;
            grp      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
          end
        end
        BUSY: begin
          work[base +: GW] <= sub_out;
          if (grp == LAST) begin
            grp       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_state = work;

endmodule

// File: tb/tb_aes_inv_sub_bytes.sv
// Bench for aes_inv_sub_bytes: five instances (1,2,4,8,16 bytes/cycle) share one stimulus
// stream and are checked every cycle against a transaction-level model.
module tb_aes_inv_sub_bytes;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
  logic [4:0]   in_ready;
  logic [4:0]   out_valid;
  logic [127:0] out_state [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_inv_sub_bytes #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .in_state (in_state),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .out_state(out_state[g])
    );
  end

  logic [7:0]   fwd_t [256];
  logic [7:0]   inv_t [256];
  bit   [4:0]   hold;
  logic [127:0] exp_q [5];
  int           acc [5];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           tables_ready = 1'b0;
  bit           lit_en = 1'b0;
  bit   [4:0]   lit_mask = '0;
  logic [127:0] lit_exp = '0;
  bit           rnd_ready = 1'b0;

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      b = b >> 1;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_inv(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_t[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input int d, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, d, cyc, got, exp);
    end
  endtask

  // Transaction model: a DUT holds one state from acceptance until the output handshake;
  // the result becomes visible N edges after the accepting edge.
  initial begin
    hold = '0;
    for (int d = 0; d < 5; d++) begin
      acc[d]   = 0;
      exp_q[d] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 5; d++) begin
        if (rst) begin
          hold[d] = 1'b0;
        end else if (!hold[d] && in_valid) begin
          hold[d]  = 1'b1;
          exp_q[d] = model_inv(in_state);
          acc[d]   = cyc;
        end else if (hold[d] && (cyc - 1 >= acc[d] + (16 >> d)) && out_ready) begin
          hold[d] = 1'b0;
        end
      end
    end
  end

  // Table construction, model pinning and the per-cycle comparison.
  initial begin
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      fwd_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
    tables_ready = 1'b1;

    chk("pin_inv_63", 0, 128'(inv_t[8'h63]), 128'h00);
    chk("pin_inv_16", 0, 128'(inv_t[8'h16]), 128'hff);
    chk("pin_inv_7c", 0, 128'(inv_t[8'h7c]), 128'h01);
    chk("pin_inv_00", 0, 128'(inv_t[8'h00]), 128'h52);
    chk("pin_fwd_53", 0, 128'(fwd_t[8'h53]), 128'hed);
    chk("pin_vector", 0, model_inv(128'h0f0e0d0c0b0a09080706050403020100),
        128'hfbd7f3819ea340bf38a53630d56a0952);

    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int d = 0; d < 5; d++) begin
          logic ev;
          ev = hold[d] && (cyc >= acc[d] + (16 >> d));
          chk("out_valid", d, 128'(out_valid[d]), 128'(ev));
          chk("in_ready", d, 128'(in_ready[d]), 128'(!hold[d]));
          if (ev) chk("out_state", d, out_state[d], exp_q[d]);
          if (lit_en && lit_mask[d]) chk("out_state_literal", d, out_state[d], lit_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (|hold) begin
      if (rnd_ready) out_ready = 1'($urandom % 2);
      tick();
      n++;
      if (n > 300) begin
        $display("FAIL wait_idle timeout cyc=%0d hold=%b", cyc, hold);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic send(input logic [127:0] data);
    wait_idle();
    in_valid = 1'b1;
    in_state = data;
    tick();
    in_valid = 1'b0;
    in_state = rnd128();
  endtask

  initial begin
    logic [127:0] s;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_state  = rnd128();
    out_ready = 1'b1;
    wait (tables_ready);
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    lit_mask = 5'h1f;
    lit_exp  = '0;
    lit_en   = 1'b1;
    tick();
    lit_en = 1'b0;

    // Single state on the 4-byte instance, result checked on the 4th edge after accept.
    send(128'h0f0e0d0c0b0a09080706050403020100);
    repeat (4) tick();
    lit_mask = 5'b00100;
    lit_exp  = 128'hfbd7f3819ea340bf38a53630d56a0952;
    lit_en   = 1'b1;
    tick();
    lit_en = 1'b0;
    wait_idle();

    send({16{8'h63}});
    send({16{8'h16}});
    send({16{8'h7c}});
    wait_idle();

    // Backpressure with in_valid pulses while results are held.
    out_ready = 1'b0;
    send(rnd128());
    repeat (16) tick();
    repeat (10) begin
      in_valid = 1'($urandom % 2);
      in_state = rnd128();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset sampled on the 2nd BUSY edge, then a clean state.
    send(rnd128());
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(rnd128());
    wait_idle();

    // Round trip over all 256 byte values with random output backpressure.
    rnd_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) s[8*i +: 8] = fwd_t[16*j + i];
      send(s);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    repeat (400) begin
      rst       = ($urandom % 60) == 0;
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      in_state  = rnd128();
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
